// File: rtl/cotm32_pkg.sv
// Shared cotm32 types and constants for the fetch front end.
package cotm32_pkg;

    localparam int XLEN = 32;
    localparam int ILEN = 32;

    typedef enum logic [1:0] {
        S_BOOT,
        S_RUN,
        S_DRAIN,
        S_HALT
    } ifu_state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } ifu_entry_t;

endpackage

// File: rtl/ifu_fifo.sv
// Small synchronous circular FIFO with push/pop/clear and an occupancy count.
// DEPTH must be a power of two so the pointers wrap naturally.
module ifu_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   clear,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
    assign dout    = mem[rd_ptr];

    // Storage and pointer update; clear wins over push/pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/ifu.sv
// Instruction fetch unit: owns the PC, issues word fetches, buffers responses
// toward decode and handles redirects by flushing and dropping stale responses.
// Optional feature macro: IFU_MISALIGN_TRAP_EN (misaligned redirect trap).
//
// state   | meaning
// S_BOOT  | one idle cycle after reset, no requests
// S_RUN   | issuing fetches under the credit limit
// S_DRAIN | waiting for stale in-flight responses to be dropped
// S_HALT  | misaligned redirect seen; waits for an aligned redirect
module ifu
    import cotm32_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              DEPTH    = 2
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_redirect,
    input  logic [XLEN-1:0] i_redirect_pc,
    output logic            o_imem_req_valid,
    input  logic            i_imem_req_ready,
    output logic [XLEN-1:0] o_imem_req_addr,
    input  logic            i_imem_rsp_valid,
    input  logic [ILEN-1:0] i_imem_rsp_data,
    output logic            o_id_valid,
    input  logic            i_id_ready,
    output logic [XLEN-1:0] o_id_pc,
    output logic [ILEN-1:0] o_id_instr
`ifdef IFU_MISALIGN_TRAP_EN
    ,
    output logic            o_misalign,
    output logic [XLEN-1:0] o_misalign_pc
`endif
);
    localparam int CW = $clog2(DEPTH) + 1;

    ifu_state_t      state;
    ifu_state_t      state_nxt;
    logic [XLEN-1:0] pc;
    logic [CW-1:0]   drop;
    logic [CW-1:0]   drop_nxt;
    logic [CW-1:0]   aq_count;
    logic [CW-1:0]   buf_count;
    logic [XLEN-1:0] rsp_addr;
    logic            req_fire;
    logic            buf_push;
    logic            buf_pop;
    logic            misaligned;
    ifu_entry_t      buf_in;
    ifu_entry_t      buf_out;

`ifdef IFU_MISALIGN_TRAP_EN
    assign misaligned = i_redirect && (i_redirect_pc[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    assign req_fire        = o_imem_req_valid && i_imem_req_ready;
    assign o_imem_req_addr = pc;
    // A response arriving during a redirect, or while stale ones remain, is discarded.
    assign buf_push        = i_imem_rsp_valid && (drop == '0) && !i_redirect;
    assign buf_pop         = o_id_valid && i_id_ready;
    assign buf_in          = '{pc: rsp_addr, instr: i_imem_rsp_data};
    assign o_id_valid      = (buf_count != '0);
    assign o_id_pc         = buf_out.pc;
    assign o_id_instr      = buf_out.instr;

    // Issued addresses, so each response can be tagged with its PC.
    ifu_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_addr_q (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .push  (req_fire),
        .pop   (i_imem_rsp_valid),
        .clear (1'b0),
        .din   (pc),
        .dout  (rsp_addr),
        .count (aq_count)
    );

    // Instructions waiting for decode.
    ifu_fifo #(.WIDTH($bits(ifu_entry_t)), .DEPTH(DEPTH)) u_out_buf (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .push  (buf_push),
        .pop   (buf_pop),
        .clear (i_redirect),
        .din   (buf_in),
        .dout  (buf_out),
        .count (buf_count)
    );

    // Everything in flight at a redirect is stale once this cycle's response is gone.
    always_comb begin
        drop_nxt = drop;
        if (i_redirect) begin
            drop_nxt = aq_count - CW'(i_imem_rsp_valid);
        end else if (i_imem_rsp_valid && (drop != '0)) begin
            drop_nxt = drop - CW'(1);
        end
    end

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= S_BOOT;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; a redirect overrides the per-state transition.
    always_comb begin
        state_nxt = state;
        case (state)
            S_BOOT:  state_nxt = S_RUN;
            S_RUN,
            S_DRAIN: state_nxt = (drop_nxt != '0) ? S_DRAIN : S_RUN;
            S_HALT:  state_nxt = S_HALT;
            default: state_nxt = S_BOOT;
        endcase
        if (i_redirect) begin
            if (misaligned) begin
                state_nxt = S_HALT;
            end else begin
                state_nxt = (drop_nxt != '0) ? S_DRAIN : S_RUN;
            end
        end
    end

    // Fetch request valid under the credit limit of DEPTH.
    always_comb begin
        o_imem_req_valid = 1'b0;
        if ((state == S_RUN) && !i_redirect &&
            ((int'(aq_count) + int'(buf_count)) < DEPTH)) begin
            o_imem_req_valid = 1'b1;
        end
    end

    // PC and drop counter; the low PC bits are always forced to zero.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pc   <= RESET_PC;
            drop <= '0;
        end else begin
            drop <= drop_nxt;
            if (i_redirect) begin
                pc <= i_redirect_pc & ~XLEN'(3);
            end else if (req_fire) begin
                pc <= pc + XLEN'(4);
            end
        end
    end

`ifdef IFU_MISALIGN_TRAP_EN
    // Misalignment flag, cleared by the next aligned redirect.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_misalign    <= 1'b0;
            o_misalign_pc <= '0;
        end else if (i_redirect) begin
            o_misalign <= misaligned;
            if (misaligned) begin
                o_misalign_pc <= i_redirect_pc;
            end
        end
    end
`endif

endmodule
